bet_round_sequencer: RTL and testbench

//  Sequences one slot-machine play round around the player credit register:
//  - accepts coins;
//  - latches a single or max bet request and checks affordability;
//  - deducts the bet, fires the spin engine and waits for its result;
//  - credits the payout, then returns to idle.

---
 rtl/bet_round_sequencer.sv | 164 ++++++++++++++++
 tb/tb_bet_round_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bet_round_sequencer.sv
// bet_round_sequencer: one slot-machine play round around the player credit register.
// Flow: IDLE -> CHECK -> DEDUCT -> SPIN -> WAIT -> PAYOUT -> IDLE. Coins are accepted in
// every state, and every addition saturates at the register maximum.
// Optional build macro SPIN_TIMEOUT_EN adds a WAIT watchdog that refunds the bet on expiry.
module bet_round_sequencer #(
  parameter int unsigned SCORE_W      = 17,
  parameter int unsigned START_CREDIT = 10,
  parameter int unsigned SINGLE_BET   = 1,
  parameter int unsigned MAX_BET      = 5,
  parameter int unsigned COIN_VALUE   = 1,
  parameter int unsigned SPIN_TMO     = 50000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               coin_in,
  input  logic               bet_single,
  input  logic               bet_max,
  input  logic               spin_done,
  input  logic [SCORE_W-1:0] payout,
  output logic [SCORE_W-1:0] credits,
  output logic [SCORE_W-1:0] bet_amount,
  output logic               spin_start,
  output logic               busy,
  output logic               no_funds,
  output logic               timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDeduct,
    StSpin,
    StWait,
    StPayout
  } state_e;

  // Two guard bits so credits + payout + coin never wraps before saturation.
  localparam int unsigned SumW = SCORE_W + 2;
  localparam logic [SumW-1:0]    SatMax      = {2'b00, {SCORE_W{1'b1}}};
  localparam logic [SumW-1:0]    CoinAdd     = SumW'(COIN_VALUE);
  localparam logic [SCORE_W-1:0] StartCredit = SCORE_W'(START_CREDIT);
  localparam logic [SCORE_W-1:0] BetSingle   = SCORE_W'(SINGLE_BET);
  localparam logic [SCORE_W-1:0] BetMax      = SCORE_W'(MAX_BET);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] credits_q, credits_d;
  logic [SCORE_W-1:0] bet_q, bet_d;
  logic [SCORE_W-1:0] payout_q, payout_d;

  logic [SumW-1:0] coin_add;
  logic [SumW-1:0] cred_ext;
  logic [SumW-1:0] bet_ext;
  logic [SumW-1:0] payout_ext;

`ifdef SPIN_TIMEOUT_EN
  localparam logic [31:0] TmoLast = 32'(SPIN_TMO - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_spin_tmo;
  assign unused_spin_tmo = ^SPIN_TMO;
`endif

  function automatic logic [SCORE_W-1:0] sat(input logic [SumW-1:0] v);
    return (v > SatMax) ? SatMax[SCORE_W-1:0] : v[SCORE_W-1:0];
  endfunction

  assign coin_add   = coin_in ? CoinAdd : '0;
  assign cred_ext   = {2'b00, credits_q};
  assign bet_ext    = {2'b00, bet_q};
  assign payout_ext = {2'b00, payout_q};

  assign credits    = credits_q;
  assign bet_amount = bet_q;
  assign busy       = (state_q != StIdle);

  // Next-state, credit arithmetic and the Moore/Mealy pulse outputs.
  always_comb begin
    state_d    = state_q;
    bet_d      = bet_q;
    payout_d   = payout_q;
    credits_d  = sat(cred_ext + coin_add);
    spin_start = 1'b0;
    no_funds   = 1'b0;
    timeout    = 1'b0;
`ifdef SPIN_TIMEOUT_EN
    tmo_cnt_d  = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bet_max) begin
          bet_d   = BetMax;
          state_d = StCheck;
        end else if (bet_single) begin
          bet_d   = BetSingle;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (credits_q >= bet_q) begin
          state_d = StDeduct;
        end else begin
          no_funds = 1'b1;
          state_d  = StIdle;
        end
      end
      StDeduct: begin
        // CHECK guarantees credits >= bet, so the subtraction cannot underflow.
        credits_d = sat(cred_ext - bet_ext + coin_add);
        state_d   = StSpin;
      end
      StSpin: begin
        spin_start = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (spin_done) begin
          payout_d = payout;
          state_d  = StPayout;
        end
`ifdef SPIN_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          timeout   = 1'b1;
          credits_d = sat(cred_ext + bet_ext + coin_add);
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
`endif
      end
      StPayout: begin
        credits_d = sat(cred_ext + payout_ext + coin_add);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any round in flight.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      credits_q <= StartCredit;
      bet_q     <= '0;
      payout_q  <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      bet_q     <= bet_d;
      payout_q  <= payout_d;
    end
  end

`ifdef SPIN_TIMEOUT_EN
  // Watchdog counter: counts WAIT cycles, cleared whenever WAIT is left.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bet_round_sequencer.sv
// Self-checking bench for bet_round_sequencer: expected credits are pushed to a scoreboard
// queue when a request is driven and popped when the DUT shows the matching update.
module tb_bet_round_sequencer;
  localparam int unsigned W = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         coin_in = 1'b0;
  logic         bet_single = 1'b0;
  logic         bet_max = 1'b0;
  logic         spin_done = 1'b0;
  logic [W-1:0] payout = '0;
  logic [W-1:0] credits;
  logic [W-1:0] bet_amount;
  logic         spin_start;
  logic         busy;
  logic         no_funds;
  logic         timeout;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;

  always #5 clk = ~clk;

  bet_round_sequencer #(.SPIN_TMO(16)) u_dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .coin_in   (coin_in),
    .bet_single(bet_single),
    .bet_max   (bet_max),
    .spin_done (spin_done),
    .payout    (payout),
    .credits   (credits),
    .bet_amount(bet_amount),
    .spin_start(spin_start),
    .busy      (busy),
    .no_funds  (no_funds),
    .timeout   (timeout)
  );

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input longint b);
    longint s;
    s = longint'(a) + b;
    return (s > 131071) ? 17'h1FFFF : W'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    coin_in = 0; bet_single = 0; bet_max = 0; spin_done = 0; payout = '0;
    rst = 1'b1;
    #2;
    tick();
    rst = 1'b0;
    model = 17'd10;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (credits !== 17'd10 || busy !== 1'b0 || spin_start !== 1'b0 || no_funds !== 1'b0 ||
          timeout !== 1'b0 || bet_amount !== 17'd0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: credits=%0d busy=%b spin=%b nf=%b to=%b bet=%0d, want 10/0/0/0/0/0",
                 i, credits, busy, spin_start, no_funds, timeout, bet_amount);
      end
      tick();
    end
  endtask

  // One full round: request, deduct (optional coin), spin, wait, payout.
  task automatic play_round(input bit use_max, input bit use_single, input bit coin_ded,
                            input logic [W-1:0] pay, input string name);
    logic [W-1:0] betv;
    logic [W-1:0] got;
    logic [W-1:0] e;
    int n;
    betv = use_max ? 17'd5 : 17'd1;
    e = sat_add(model - betv, longint'(coin_ded));
    exp_q.push_back(e);
    exp_q.push_back(sat_add(e, longint'(pay)));
    bet_max = use_max; bet_single = use_single;
    tick();
    bet_max = 0; bet_single = 0;
    checks++;
    if (busy !== 1'b1 || bet_amount !== betv || spin_start !== 1'b0) begin
      failures++;
      $display("FAIL %s_check: busy=%b bet=%0d spin=%b, want 1/%0d/0", name, busy, bet_amount,
               spin_start, betv);
    end
    tick();
    coin_in = coin_ded;
    checks++;
    if (spin_start !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_spin: spin_start=%b want 0", name, spin_start);
    end
    tick();
    coin_in = 0;
    got = exp_q.pop_front();
    checks++;
    if (spin_start !== 1'b1 || credits !== got) begin
      failures++;
      $display("FAIL %s_spin_n3: spin=%b credits=%0d, want 1/%0d", name, spin_start, credits, got);
    end
    tick();
    checks++;
    if (spin_start !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_spin_pulse: spin=%b busy=%b, want 0/1", name, spin_start, busy);
    end
    bet_single = 1;  // must be ignored in WAIT
    tick();
    bet_single = 0;
    tick();
    spin_done = 1; payout = pay;
    tick();
    spin_done = 0; payout = '0;
    n = 0;
    while (busy && n < 5) begin
      tick();
      n++;
    end
    got = exp_q.pop_front();
    checks++;
    if (busy !== 1'b0 || credits !== got) begin
      failures++;
      $display("FAIL %s_payout: busy=%b credits=%0d, want 0/%0d", name, busy, credits, got);
    end
    model = got;
    tick();
    checks++;
    if (busy !== 1'b0 || credits !== model) begin
      failures++;
      $display("FAIL %s_not_queued: busy=%b credits=%0d, want 0/%0d", name, busy, credits, model);
    end
  endtask

  task automatic test_basic_rounds();
    do_reset();
    play_round(0, 1, 0, 17'd0, "single_pay0");   // 10 -> 9
    do_reset();
    play_round(1, 0, 0, 17'd20, "max_pay20");    // 10 -> 5 -> 25
  endtask

  task automatic test_no_funds();
    logic [W-1:0] got;
    do_reset();
    play_round(1, 0, 0, 17'd0, "to5");
    play_round(0, 1, 0, 17'd0, "to4");
    exp_q.push_back(model);
    bet_max = 1;
    tick();
    bet_max = 0;
    checks++;
    if (no_funds !== 1'b1 || spin_start !== 1'b0) begin
      failures++;
      $display("FAIL nofunds_pulse: no_funds=%b spin=%b, want 1/0", no_funds, spin_start);
    end
    tick();
    got = exp_q.pop_front();
    checks++;
    if (no_funds !== 1'b0 || busy !== 1'b0 || credits !== got) begin
      failures++;
      $display("FAIL nofunds_idle: nf=%b busy=%b credits=%0d, want 0/0/%0d", no_funds, busy,
               credits, got);
    end
    tick();
    checks++;
    if (spin_start !== 1'b0 || credits !== 17'd4) begin
      failures++;
      $display("FAIL nofunds_nospin: spin=%b credits=%0d, want 0/4", spin_start, credits);
    end
    play_round(0, 1, 0, 17'd0, "single_at4");    // 4 -> 3
  endtask

  task automatic test_coins();
    do_reset();
    play_round(1, 0, 1, 17'd0, "coin_deduct");   // 10 - 5 + 1 = 6
    play_round(1, 1, 0, 17'd0, "both_bets");     // max wins: 6 -> 1
    coin_in = 1;
    tick();
    coin_in = 0;
    model = sat_add(model, 1);
    checks++;
    if (credits !== model) begin
      failures++;
      $display("FAIL coin_idle: credits=%0d want %0d", credits, model);
    end
    spin_done = 1; payout = 17'd7;               // ignored outside WAIT
    tick();
    spin_done = 0; payout = '0;
    tick();
    checks++;
    if (credits !== model || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_spin_done: credits=%0d busy=%b, want %0d/0", credits, busy, model);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    play_round(0, 1, 0, 17'd131061, "to_131070"); // 10 -> 9 -> 131070
    play_round(0, 1, 0, 17'd9, "sat_payout");     // 131069 + 9 -> 131071
    coin_in = 1;
    tick();
    coin_in = 0;
    checks++;
    if (credits !== 17'h1FFFF) begin
      failures++;
      $display("FAIL sat_coin: credits=%0d want 131071", credits);
    end
  endtask

  task automatic test_reset_mid_round();
    do_reset();
    bet_max = 1;
    tick();
    bet_max = 0;
    for (int i = 0; i < 4; i++) tick();          // now in WAIT, 5 deducted
    rst = 1'b1;
    #2;
    checks++;
    if (credits !== 17'd10 || busy !== 1'b0 || spin_start !== 1'b0 || bet_amount !== 17'd0) begin
      failures++;
      $display("FAIL reset_mid: credits=%0d busy=%b spin=%b bet=%0d, want 10/0/0/0", credits,
               busy, spin_start, bet_amount);
    end
    tick();
    rst = 1'b0;
    model = 17'd10;
  endtask

  task automatic test_watchdog();
    int k;
    bit seen_to;
    do_reset();
    bet_single = 1;
    tick();
    bet_single = 0;
    tick();
    tick();                                       // SPIN
    tick();                                       // WAIT cycle 1
    k = 1;
`ifdef SPIN_TIMEOUT_EN
    while (!timeout && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (timeout !== 1'b1 || k != 16) begin
      failures++;
      $display("FAIL timeout_cycle: timeout=%b at WAIT cycle %0d, want 1 at 16", timeout, k);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || credits !== 17'd10 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_refund: busy=%b credits=%0d to=%b, want 0/10/0", busy, credits,
               timeout);
    end
`else
    seen_to = 1'b0;
    while (k < 40) begin
      if (timeout !== 1'b0 || busy !== 1'b1) seen_to = 1'b1;
      tick();
      k++;
    end
    checks++;
    if (seen_to) begin
      failures++;
      $display("FAIL wait_hold: timeout or idle seen during WAIT, want hold with timeout=0");
    end
    spin_done = 1;
    tick();
    spin_done = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || credits !== 17'd9) begin
      failures++;
      $display("FAIL wait_release: busy=%b credits=%0d, want 0/9", busy, credits);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_rounds();
    test_no_funds();
    test_coins();
    test_saturation();
    test_reset_mid_round();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
